// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: merges ID/EX/MEM stall requests and exceptions
// into a stall bus, a flush pulse and a redirect PC; supervises the divider.
//
// state    | meaning
// IDLE     | no multi-cycle operation in flight
// DIV_BUSY | divider running; EX stalled until div_done, exception or reset
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        div_done,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic        excp_is_eret,
  input  logic [31:0] epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        div_cancel,
  output logic        div_timeout
);

  localparam logic [31:0] EXCP_VECTOR = 32'hBFC0_0380;
  localparam logic [5:0]  STALL_ID    = 6'b001111;
  localparam logic [5:0]  STALL_EX    = 6'b011111;
  localparam logic [5:0]  STALL_MEM   = 6'b111111;

  typedef enum logic [0:0] {IDLE, DIV_BUSY} state_t;

  state_t      state, state_nxt;
  logic [5:0]  wait_cnt, wait_cnt_nxt;
  logic        timeout_nxt;
  logic        pend, pend_eret;
  logic [31:0] pend_epc;

  logic        exc_taken;
  logic        exc_eret;
  logic [31:0] exc_epc;
  logic        ex_req;

  // A latched (older) exception always wins over one presented this cycle.
  assign exc_taken = rst && (excp_valid || pend) && !stallreq_mem;
  assign exc_eret  = pend ? pend_eret : excp_is_eret;
  assign exc_epc   = pend ? pend_epc  : epc;
  assign ex_req    = (state == DIV_BUSY) ? !div_done : stallreq_ex;

  always_comb begin
    stall        = 6'b000000;
    flush        = 1'b0;
    new_pc       = 32'h0;
    div_cancel   = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = div_timeout;
    if (!rst) begin
      state_nxt    = IDLE;
      wait_cnt_nxt = 6'd0;
      timeout_nxt  = 1'b0;
    end else if (exc_taken) begin
      flush      = 1'b1;
      new_pc     = exc_eret ? exc_epc : EXCP_VECTOR;
      div_cancel = (state == DIV_BUSY);
      state_nxt  = IDLE;
    end else begin
      if (stallreq_mem)     stall = STALL_MEM;
      else if (ex_req)      stall = STALL_EX;
      else if (stallreq_id) stall = STALL_ID;

      case (state)
        IDLE: begin
          if (stallreq_ex && !stallreq_mem) begin
            state_nxt    = DIV_BUSY;
            wait_cnt_nxt = 6'd0;
          end
        end
        DIV_BUSY: begin
          if (div_done) begin
            state_nxt = IDLE;
          end else begin
            // Flag as the counter reaches 63 so the error is visible on that cycle.
            if (wait_cnt >= 6'd62) timeout_nxt = 1'b1;
            if (wait_cnt != 6'd63) wait_cnt_nxt = wait_cnt + 6'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state       <= state_nxt;
    wait_cnt    <= wait_cnt_nxt;
    div_timeout <= timeout_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend      <= 1'b0;
      pend_eret <= 1'b0;
      pend_epc  <= 32'h0;
    end else if (exc_taken) begin
      pend <= 1'b0;
    end else if (excp_valid && stallreq_mem && !pend) begin
      pend      <= 1'b1;
      pend_eret <= excp_is_eret;
      pend_epc  <= epc;
    end
  end

endmodule
